// File: rtl/sram_controller.sv
// Sequences 32-bit data-memory accesses onto a 16-bit asynchronous SRAM as a
// low-half phase followed by a high-half phase, stalling the pipeline via ready.
module sram_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 3,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic                op_wr;
  logic [SRAM_AW-2:0]  waddr_q;
  logic [31:0]         wdata_q;
  logic [15:0]         rd_lo;
  logic [31:0]         offset;
  logic                req;
  logic                phase_end;
  logic                unused_offset_bits;

  assign req       = wr_en | rd_en;
  assign offset    = address - 32'(BASE_ADDR);
  assign phase_end = (cnt == LAST);
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= '0;
      else if (state == LO || state == HI)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = LO;
      LO:   if (phase_end) state_nx = HI;
      HI:   if (phase_end) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latches and read-half capture; read_data is loaded on the HI->DONE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rd_lo     <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_wr   <= wr_en;
        waddr_q <= offset[SRAM_AW:2];
        wdata_q <= write_data;
      end
      if (state == LO && phase_end && !op_wr)
        rd_lo <= sram_dq_in;
      if (state == HI && phase_end && !op_wr)
        read_data <= {sram_dq_in, rd_lo};
    end
  end

  // SRAM pins decode only registered state, so they are glitch-free w.r.t. inputs.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (state == LO || state == HI) begin
      sram_addr = {waddr_q, (state == HI)};
      if (op_wr) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
        sram_we_n   = !(cnt < LAST);
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ready = ((state == IDLE) && !req) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a behavioural
// 16-bit SRAM model on the split data bus (default parameters, N=3).
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic [15:0] mem [0:262143];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  sram_controller #(
    .BASE_ADDR(1024),
    .ACCESS_CYCLES(3),
    .SRAM_AW(18)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];

  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;
  end

  // Presents a request in the next cycle (cycle 0) and checks ready drops.
  task automatic start(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1;
    n_total++;
    if (ready !== 1'b0) $display("FAIL start_ready_c0 got=%b exp=0", ready);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110)
      $display("FAIL reset_strobes got=%b exp=1110", {ready, sram_we_n, sram_oe_n, sram_dq_oe});
    else n_pass++;
    n_total++;
    if ({read_data, sram_addr, sram_dq_out} !== 66'h0)
      $display("FAIL reset_data got=%h/%h/%h exp=0", read_data, sram_addr, sram_dq_out);
    else n_pass++;
    rst = 1'b1;
    // Abort a write in LO at cnt=1
    start(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    @(negedge clk); wr_en = 0;
    @(negedge clk);
    n_total++;
    if (sram_we_n !== 1'b0) $display("FAIL abort_pre_we_n got=%b exp=0", sram_we_n);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({sram_we_n, sram_dq_oe} !== 2'b10)
      $display("FAIL abort_async got=%b exp=10", {sram_we_n, sram_dq_oe});
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({ready, sram_we_n, sram_oe_n, sram_addr} !== {3'b111, 18'h0})
      $display("FAIL abort_release got=%b/%h exp=111/0", {ready, sram_we_n, sram_oe_n}, sram_addr);
    else n_pass++;
  endtask

  task automatic test_write;
    logic [17:0] ea;
    logic [15:0] ed;
    start(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) wr_en = 0;
      if (c <= 6) begin
        ea = (c <= 3) ? 18'd2 : 18'd3;
        ed = (c <= 3) ? 16'hBEEF : 16'hDEAD;
        n_total++;
        if (sram_addr !== ea || sram_dq_out !== ed || sram_dq_oe !== 1'b1)
          $display("FAIL write_bus c%0d got=%h/%h/%b exp=%h/%h/1", c, sram_addr, sram_dq_out, sram_dq_oe, ea, ed);
        else n_pass++;
        n_total++;
        if (sram_we_n !== (c == 3 || c == 6))
          $display("FAIL write_we_n c%0d got=%b exp=%b", c, sram_we_n, (c == 3 || c == 6));
        else n_pass++;
      end
      n_total++;
      if (ready !== (c == 7)) $display("FAIL write_ready c%0d got=%b exp=%b", c, ready, (c == 7));
      else n_pass++;
    end
    n_total++;
    if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD)
      $display("FAIL write_mem got=%h%h exp=deadbeef", mem[3], mem[2]);
    else n_pass++;
  endtask

  task automatic test_read;
    mem[2] = 16'hBEEF; mem[3] = 16'hDEAD;
    start(1'b0, 1'b1, 32'd1028, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) rd_en = 0;
      if (c <= 6) begin
        n_total++;
        if (sram_oe_n !== 1'b0 || sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1)
          $display("FAIL read_strobes c%0d got=%b%b%b exp=010", c, sram_oe_n, sram_dq_oe, sram_we_n);
        else n_pass++;
      end
      if (c == 6) begin
        n_total++;
        if (read_data !== 32'h0) $display("FAIL read_early got=%h exp=00000000", read_data);
        else n_pass++;
      end
    end
    n_total++;
    if (ready !== 1'b1 || read_data !== 32'hDEADBEEF)
      $display("FAIL read_done got=%b/%h exp=1/deadbeef", ready, read_data);
    else n_pass++;
    start(1'b1, 1'b0, 32'd1040, 32'h12345678);
    @(negedge clk); wr_en = 0;
    repeat (7) @(negedge clk);
    n_total++;
    if (read_data !== 32'hDEADBEEF || mem[8] !== 16'h5678 || mem[9] !== 16'h1234)
      $display("FAIL read_hold got=%h mem=%h%h exp=deadbeef/12345678", read_data, mem[9], mem[8]);
    else n_pass++;
  endtask

  task automatic test_both;
    start(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin wr_en = 0; rd_en = 0; end
      n_total++;
      if (sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b1)
        $display("FAIL both_strobes c%0d got=%b%b exp=11", c, sram_oe_n, sram_dq_oe);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (read_data !== 32'hDEADBEEF || mem[4] !== 16'hF00D || mem[5] !== 16'hCAFE)
      $display("FAIL both_result got=%h mem=%h%h exp=deadbeef/cafef00d", read_data, mem[5], mem[4]);
    else n_pass++;
  endtask

  task automatic test_input_change;
    start(1'b1, 1'b0, 32'd1036, 32'h11112222);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) wr_en = 0;
      if (c == 4) begin address = 32'd1100; write_data = 32'hFFFFFFFF; wr_en = 1; end
      if (c >= 4 && c <= 6) begin
        n_total++;
        if (sram_addr !== 18'd7 || sram_dq_out !== 16'h1111)
          $display("FAIL chg_bus c%0d got=%h/%h exp=7/1111", c, sram_addr, sram_dq_out);
        else n_pass++;
      end
      if (c == 6) wr_en = 0;
    end
    n_total++;
    if (mem[6] !== 16'h2222 || mem[7] !== 16'h1111)
      $display("FAIL chg_mem got=%h%h exp=11112222", mem[7], mem[6]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    mem[10] = 16'h3344; mem[11] = 16'h1122;
    mem[12] = 16'hCCDD; mem[13] = 16'hAABB;
    start(1'b0, 1'b1, 32'd1044, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 7) begin
        n_total++;
        if (ready !== 1'b1 || read_data !== 32'h11223344)
          $display("FAIL b2b_first got=%b/%h exp=1/11223344", ready, read_data);
        else n_pass++;
        address = 32'd1048;
      end
      if (c == 8 || c == 14) begin
        n_total++;
        if (ready !== 1'b0) $display("FAIL b2b_stall c%0d got=%b exp=0", c, ready);
        else n_pass++;
      end
      if (c == 9) rd_en = 0;
    end
    n_total++;
    if (ready !== 1'b1 || read_data !== 32'hAABBCCDD)
      $display("FAIL b2b_second got=%b/%h exp=1/aabbccdd", ready, read_data);
    else n_pass++;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    n_total++;
    if ({ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110)
      $display("FAIL idle_quiet got=%b exp=1110", {ready, sram_we_n, sram_oe_n, sram_dq_oe});
    else n_pass++;
    start(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) wr_en = 0;
      if (c == 1 || c == 4) begin
        n_total++;
        if (sram_addr !== ((c == 1) ? 18'h3FFFE : 18'h3FFFF))
          $display("FAIL wrap_addr c%0d got=%h exp=%h", c, sram_addr, (c == 1) ? 18'h3FFFE : 18'h3FFFF);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_total++;
    if (mem[18'h3FFFE] !== 16'h5A5A || mem[18'h3FFFF] !== 16'hA5A5)
      $display("FAIL wrap_mem got=%h%h exp=a5a55a5a", mem[18'h3FFFF], mem[18'h3FFFE]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_both();
    test_input_change();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
